// File: rtl/edge_x_locator.sv
// rtl/edge_x_locator.sv - leftmost edge-pixel X inside a row window, reported once per frame
module edge_x_locator #(
  parameter int STROBE_LEN = 4,
  parameter bit VS_POL     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        vsync,
  input  logic        de,
  input  logic        edge_pix,
  input  logic [11:0] roi_y_start,
  input  logic [11:0] roi_y_end,
  output logic [11:0] x_pos,
  output logic        x_strobe,
  output logic        x_found
);

  localparam int          SW    = $clog2(STROBE_LEN + 1);
  localparam logic [11:0] X_MAX = 12'hFFF;

  typedef enum logic [1:0] {IDLE, ARM, SCAN} state_t;

  state_t        state, state_n;
  logic          vs_d1, vs_d2, de_d;
  logic          vs_rise, de_fall;
  logic [11:0]   x_cnt, y_cnt;
  logic [11:0]   min_x, min_n;
  logic          found, found_n;
  logic          rep_v, rep_n;
  logic [11:0]   rep_x, rep_x_n;
  logic          rep_found, rep_found_n;
  logic [SW-1:0] strb_cnt;
  logic          in_roi, hit;

  assign vs_rise = vs_d1 & ~vs_d2;
  assign de_fall = de_d & ~de;
  // start > end makes both bounds impossible to meet at once, so the window is empty
  assign in_roi  = (y_cnt >= roi_y_start) && (y_cnt <= roi_y_end);
  assign hit     = de && edge_pix && in_roi && (x_cnt < min_x);

  // Frame-sync and data-enable delay flops used for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d1 <= 1'b0;
      vs_d2 <= 1'b0;
      de_d  <= 1'b0;
    end else begin
      vs_d1 <= (vsync == VS_POL);
      vs_d2 <= vs_d1;
      de_d  <= de;
    end
  end

  // Pixel column counter: holds the current pixel's X while de is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
    end else if (!de) begin
      x_cnt <= '0;
    end else if (x_cnt != X_MAX) begin
      x_cnt <= x_cnt + 12'd1;
    end
  end

  // Line counter: advances at the end of each line, restarts at frame sync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_cnt <= '0;
    end else if (vs_rise) begin
      y_cnt <= '0;
    end else if (de_fall && (y_cnt != X_MAX)) begin
      y_cnt <= y_cnt + 12'd1;
    end
  end

  // FSM state, running minimum and the one-cycle report stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      min_x     <= X_MAX;
      found     <= 1'b0;
      rep_v     <= 1'b0;
      rep_x     <= '0;
      rep_found <= 1'b0;
    end else begin
      state     <= state_n;
      min_x     <= min_n;
      found     <= found_n;
      rep_v     <= rep_n;
      rep_x     <= rep_x_n;
      rep_found <= rep_found_n;
    end
  end

  // Next-state logic; a pixel coinciding with vs_rise is folded into the ending frame's report
  always_comb begin
    state_n     = state;
    min_n       = min_x;
    found_n     = found;
    rep_n       = 1'b0;
    rep_x_n     = rep_x;
    rep_found_n = rep_found;
    case (state)
      IDLE: begin
        min_n   = X_MAX;
        found_n = 1'b0;
        if (en) state_n = ARM;
      end
      ARM: begin
        if (vs_rise) begin
          min_n   = X_MAX;
          found_n = 1'b0;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          min_n   = x_cnt;
          found_n = 1'b1;
        end
        if (vs_rise) begin
          rep_n       = 1'b1;
          rep_x_n     = hit ? x_cnt : min_x;
          rep_found_n = found | hit;
          min_n       = X_MAX;
          found_n     = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        min_n   = X_MAX;
        found_n = 1'b0;
      end
    endcase
    if (!en) begin
      state_n = IDLE;
      rep_n   = 1'b0;
      min_n   = X_MAX;
      found_n = 1'b0;
    end
  end

  // Output registers: latch the report and run the strobe counter (restarts on a new report)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_pos    <= '0;
      x_found  <= 1'b0;
      strb_cnt <= '0;
    end else if (!en) begin
      strb_cnt <= '0;
    end else if (rep_v && rep_found) begin
      x_pos    <= rep_x;
      x_found  <= 1'b1;
      strb_cnt <= SW'(STROBE_LEN);
    end else begin
      if (rep_v) x_found <= 1'b0;
      if (strb_cnt != '0) strb_cnt <= strb_cnt - SW'(1);
    end
  end

  // Strobe is gated by en so it drops in the same cycle the block is disabled
  assign x_strobe = en && (strb_cnt != '0);

endmodule

// File: tb/tb_edge_x_locator.sv
// tb/tb_edge_x_locator.sv - directed self-checking bench for edge_x_locator
module tb_edge_x_locator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        vsync;
  logic        de;
  logic        edge_pix;
  logic [11:0] roi_y_start;
  logic [11:0] roi_y_end;
  logic [11:0] x_pos;
  logic        x_strobe;
  logic        x_found;

  int n_chk = 0;
  int n_err = 0;

  edge_x_locator #(.STROBE_LEN(4), .VS_POL(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .vsync       (vsync),
    .de          (de),
    .edge_pix    (edge_pix),
    .roi_y_start (roi_y_start),
    .roi_y_end   (roi_y_end),
    .x_pos       (x_pos),
    .x_strobe    (x_strobe),
    .x_found     (x_found)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_line(input int width, input int ex);
    for (int i = 0; i < width; i++) begin
      @(negedge clk);
      de       = 1'b1;
      edge_pix = (i == ex);
    end
    @(negedge clk);
    de       = 1'b0;
    edge_pix = 1'b0;
    idle(2);
  endtask

  // Rows of 8 pixels; a row carrying an edge is widened to reach that edge's column
  task automatic send_frame(input int nrows, input int ey0, input int ex0,
                            input int ey1, input int ex1, input int ey2, input int ex2);
    int ex;
    int w;
    idle(3);
    for (int y = 0; y < nrows; y++) begin
      ex = -1;
      if (y == ey0) ex = ex0;
      if (y == ey1) ex = ex1;
      if (y == ey2) ex = ex2;
      w = (ex + 1 > 8) ? ex + 1 : 8;
      send_line(w, ex);
    end
  endtask

  // vsync captured at edge k: outputs must be unchanged after k+1, strobe high after k+2..k+5
  task automatic do_vsync(input string tag, input bit exp_stb, input int exp_x, input bit exp_fnd);
    @(negedge clk);
    vsync = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 chk({tag, "_stb_pre"}, 32'(x_strobe), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 chk({tag, "_stb"}, 32'(x_strobe), 32'(exp_stb));
      if (i == 0) begin
        chk({tag, "_x_pos"}, 32'(x_pos), 32'(exp_x));
        chk({tag, "_x_found"}, 32'(x_found), 32'(exp_fnd));
      end
    end
    @(posedge clk);
    #1 chk({tag, "_stb_post"}, 32'(x_strobe), 32'd0);
    @(negedge clk);
    vsync = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    en          = 1'b0;
    vsync       = 1'b0;
    de          = 1'b0;
    edge_pix    = 1'b0;
    roi_y_start = 12'd10;
    roi_y_end   = 12'd50;

    // reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      en       = 1'($urandom);
      vsync    = 1'($urandom);
      de       = 1'($urandom);
      edge_pix = 1'($urandom);
      #1;
      chk("rst_x_pos", 32'(x_pos), 32'd0);
      chk("rst_x_strobe", 32'(x_strobe), 32'd0);
      chk("rst_x_found", 32'(x_found), 32'd0);
    end
    @(negedge clk);
    en = 1'b1; vsync = 1'b0; de = 1'b0; edge_pix = 1'b0;
    idle(2);
    rst_n = 1'b1;

    // partial first frame with an ROI edge: the first vsync only arms
    send_frame(25, 20, 3, -1, -1, -1, -1);
    do_vsync("t1_arm", 1'b0, 0, 1'b0);

    // single edge at (100,20)
    send_frame(21, 20, 100, -1, -1, -1, -1);
    do_vsync("t2", 1'b1, 100, 1'b1);

    // (300,15), (120,40) in ROI, (5,60) outside
    send_frame(61, 15, 300, 40, 120, 60, 5);
    do_vsync("t3", 1'b1, 120, 1'b1);

    // edges only outside ROI
    send_frame(61, 60, 2, 55, 1, 5, 0);
    do_vsync("t4", 1'b0, 120, 1'b0);

    // single-row ROI, x=0 then x=1279 with neighbouring rows holding smaller X
    roi_y_start = 12'd30;
    roi_y_end   = 12'd30;
    send_frame(32, 30, 0, -1, -1, -1, -1);
    do_vsync("t5_x0", 1'b1, 0, 1'b1);
    send_frame(32, 29, 2, 30, 1279, 31, 2);
    do_vsync("t5_x1279", 1'b1, 1279, 1'b1);

    // start > end: empty window
    roi_y_start = 12'd40;
    roi_y_end   = 12'd20;
    send_frame(32, 30, 4, -1, -1, -1, -1);
    do_vsync("t5_empty", 1'b0, 1279, 1'b0);

    // en dropped mid-frame
    roi_y_start = 12'd10;
    roi_y_end   = 12'd50;
    send_frame(15, 12, 4, -1, -1, -1, -1);
    en = 1'b0;
    idle(3);
    en = 1'b1;
    send_frame(10, -1, -1, -1, -1, -1, -1);
    do_vsync("t6_en_arm", 1'b0, 1279, 1'b0);
    send_frame(15, 12, 6, -1, -1, -1, -1);
    do_vsync("t6_en", 1'b1, 6, 1'b1);

    // rst_n pulse mid-frame
    send_frame(15, 12, 2, -1, -1, -1, -1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_x_pos", 32'(x_pos), 32'd0);
    chk("t6_rst_x_found", 32'(x_found), 32'd0);
    idle(2);
    rst_n = 1'b1;
    send_frame(10, -1, -1, -1, -1, -1, -1);
    do_vsync("t6_rst_arm", 1'b0, 0, 1'b0);
    send_frame(15, 12, 11, -1, -1, -1, -1);
    do_vsync("t6_rst", 1'b1, 11, 1'b1);

    // en dropped while strobing: strobe falls at once, x_pos/x_found hold
    send_frame(15, 12, 13, -1, -1, -1, -1);
    @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("t7_stb_on", 32'(x_strobe), 32'd1);
    en = 1'b0;
    #1;
    chk("t7_stb_off", 32'(x_strobe), 32'd0);
    chk("t7_x_pos", 32'(x_pos), 32'd13);
    chk("t7_x_found", 32'(x_found), 32'd1);
    @(negedge clk);
    vsync = 1'b0;
    en    = 1'b1;
    idle(6);
    chk("t7_stb_idle", 32'(x_strobe), 32'd0);
    chk("t7_x_pos_hold", 32'(x_pos), 32'd13);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
